// File: rtl/wb_mem_responder_pkg.sv
// Shared types and constants for the Wishbone memory responder.
// The FSM state type, the bus widths and the address range check live here.
package wb_resp_pkg;

    localparam int WB_DW   = 128;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_resp_state_t;

    // Any address bit above the line index marks the access as out of range.
    function automatic logic addrOutOfRange(input logic [WB_AW-1:0] adr, input int lineBits);
        return (adr >> (4 + lineBits)) != '0;
    endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone B3 classic bus bundle between the core (master) and the memory responder (slave).
interface wb_mem_responder_if;
    import wb_resp_pkg::*;

    logic [WB_AW-1:0]   adr;
    logic [WB_SELW-1:0] sel;
    logic               we;
    logic [WB_DW-1:0]   dat;
    logic               cyc;
    logic               stb;
    logic [WB_DW-1:0]   rdat;
    logic               ack;
    logic               err;

    modport master (
        output adr, sel, we, dat, cyc, stb,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, sel, we, dat, cyc, stb,
        output rdat, ack, err
    );

endinterface

// File: rtl/wb_mem_responder_mem.sv
// Line memory behind the responder: one registered read port, one byte-lane write port
// and a 32-bit word load port whose bytes are overridden by the bus port on collision.
module wb_resp_mem
    import wb_resp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic [WB_DW-1:0]           o_rd_data,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_idx,
    input  logic [WB_SELW-1:0]         i_wr_sel,
    input  logic [WB_DW-1:0]           i_wr_data,
    input  logic                       i_ld_we,
    input  logic [$clog2(DEPTH)+1:0]   i_ld_idx,
    input  logic [31:0]                i_ld_word
);

    localparam int LW = $clog2(DEPTH);

    logic [WB_DW-1:0] r_mem [DEPTH];
    logic [WB_DW-1:0] r_rd_data;

    logic [LW-1:0] w_ld_line;
    logic [6:0]    w_ld_off;

    assign w_ld_line = i_ld_idx[LW+1:2];
    assign w_ld_off  = {i_ld_idx[1:0], 5'b0};

    // Load goes first so that the later bus byte assignments win on shared bytes.
    always_ff @(posedge i_clk) begin
        if (i_ld_we) begin
            r_mem[w_ld_line][w_ld_off +: 32] <= i_ld_word;
        end
        if (i_wr_en) begin
            for (int b = 0; b < WB_SELW; b++) begin
                if (i_wr_sel[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B3 classic slave fronting the line memory: request capture, wait-state
// counter, range check and the IDLE/WAIT/RESP handshake FSM.
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    wb_mem_responder_if.slave          wb,
    input  logic                       i_ld_we,
    input  logic [$clog2(DEPTH)+1:0]   i_ld_idx,
    input  logic [31:0]                i_ld_word
);

    localparam int         LW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_resp_state_t r_state;
    wb_resp_state_t w_next_state;

    logic [3:0]         r_cnt;
    logic [LW-1:0]      r_idx;
    logic               r_we;
    logic               r_oor;
    logic [WB_SELW-1:0] r_sel;
    logic [WB_DW-1:0]   r_dat;

    logic               w_req;
    logic               w_idle;
    logic               w_in_oor;
    logic [LW-1:0]      w_in_idx;
    logic [LW-1:0]      w_cur_idx;
    logic               w_cur_we;
    logic               w_cur_oor;
    logic [WB_SELW-1:0] w_cur_sel;
    logic [WB_DW-1:0]   w_cur_dat;
    logic               w_enter_resp;
    logic               w_wr_en;
    logic               w_rd_en;
    logic               w_ack;
    logic               w_err;
    logic [WB_DW-1:0]   w_rd_data;

    assign w_req    = wb.cyc & wb.stb;
    assign w_idle   = (r_state == IDLE);
    assign w_in_oor = addrOutOfRange(wb.adr, LW);
    assign w_in_idx = wb.adr[4+LW-1:4];

    // With no wait states RESP is entered on the capture edge itself, so the
    // memory access must use the live bus values rather than the capture registers.
    assign w_cur_idx = w_idle ? w_in_idx  : r_idx;
    assign w_cur_we  = w_idle ? wb.we     : r_we;
    assign w_cur_oor = w_idle ? w_in_oor  : r_oor;
    assign w_cur_sel = w_idle ? wb.sel    : r_sel;
    assign w_cur_dat = w_idle ? wb.dat    : r_dat;

    assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);
    assign w_wr_en      = w_enter_resp && w_cur_we && !w_cur_oor;
    assign w_rd_en      = w_enter_resp && !w_cur_we && !w_cur_oor;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!wb.cyc) begin
                    w_next_state = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Gating with cyc keeps ACK/ERR quiet if the master walks away in the response cycle.
    always_comb begin
        w_ack = 1'b0;
        w_err = 1'b0;
        if (r_state == RESP && wb.cyc) begin
            w_ack = !r_oor;
            w_err = r_oor;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 4'd0;
        end else if (w_idle && w_req) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == WAIT && wb.cyc && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
            r_we  <= 1'b0;
            r_oor <= 1'b0;
            r_sel <= '0;
            r_dat <= '0;
        end else if (w_idle && w_req) begin
            r_idx <= w_in_idx;
            r_we  <= wb.we;
            r_oor <= w_in_oor;
            r_sel <= wb.sel;
            r_dat <= wb.dat;
        end
    end

    wb_resp_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_cur_idx),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_cur_idx),
        .i_wr_sel  (w_cur_sel),
        .i_wr_data (w_cur_dat),
        .i_ld_we   (i_ld_we),
        .i_ld_idx  (i_ld_idx),
        .i_ld_word (i_ld_word)
    );

    assign wb.rdat = w_rd_data;
    assign wb.ack  = w_ack;
    assign wb.err  = w_err;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: one instance without wait states, one with three.
module tb_wb_mem_responder;

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2 = 128'h00112233_44556677_8899AABB_FFFFFFFF;
    localparam logic [127:0] D3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] D4 = 128'h55555555_66666666_77777777_88888888;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst3;
    logic        ldWe;
    logic [9:0]  ldIdx;
    logic [31:0] ldWord;
    logic        ldWeOff = 1'b0;
    logic [9:0]  ldIdxOff = '0;
    logic [31:0] ldWordOff = '0;

    int checks = 0;
    int errors = 0;

    wb_mem_responder_if bus0 ();
    wb_mem_responder_if bus3 ();

    wb_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .i_clk     (clk),
        .i_rst     (rst0),
        .wb        (bus0.slave),
        .i_ld_we   (ldWe),
        .i_ld_idx  (ldIdx),
        .i_ld_word (ldWord)
    );

    wb_mem_responder #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
        .i_clk     (clk),
        .i_rst     (rst3),
        .wb        (bus3.slave),
        .i_ld_we   (ldWeOff),
        .i_ld_idx  (ldIdxOff),
        .i_ld_word (ldWordOff)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic driveBus(input int d, input logic c, input logic s, input logic w,
                            input logic [31:0] a, input logic [15:0] sl, input logic [127:0] dt);
        if (d == 3) begin
            bus3.cyc = c; bus3.stb = s; bus3.we = w; bus3.adr = a; bus3.sel = sl; bus3.dat = dt;
        end else begin
            bus0.cyc = c; bus0.stb = s; bus0.we = w; bus0.adr = a; bus0.sel = sl; bus0.dat = dt;
        end
    endtask

    function automatic logic getAck(input int d);
        return (d == 3) ? bus3.ack : bus0.ack;
    endfunction

    function automatic logic getErr(input int d);
        return (d == 3) ? bus3.err : bus0.err;
    endfunction

    function automatic logic [127:0] getDat(input int d);
        return (d == 3) ? bus3.rdat : bus0.rdat;
    endfunction

    // One full classic cycle: latency counts edges from request capture to ACK/ERR seen.
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                 input logic [15:0] sl, input logic [127:0] dt,
                                 output int lat, output logic ak, output logic er,
                                 output logic [127:0] rd, output logic akNext);
        @(negedge clk);
        driveBus(d, 1'b1, 1'b1, w, a, sl, dt);
        lat = 0;
        ak  = 1'b0;
        er  = 1'b0;
        while (lat < 20 && ak !== 1'b1 && er !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
            ak = getAck(d);
            er = getErr(d);
        end
        if (ak !== 1'b1 && er !== 1'b1) lat = 99;
        rd = getDat(d);
        driveBus(d, 1'b1, 1'b0, w, a, sl, dt);
        @(posedge clk);
        #1;
        akNext = getAck(d) | getErr(d);
        driveBus(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int           lat;
        logic         ak;
        logic         er;
        logic         akNext;
        logic         seen;
        logic [127:0] rd;

        driveBus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        driveBus(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        ldWe   = 1'b0;
        ldIdx  = '0;
        ldWord = '0;
        rst0   = 1'b1;
        rst3   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst0_ack", 128'(bus0.ack), 128'd0);
        checkOutput("rst0_err", 128'(bus0.err), 128'd0);
        checkOutput("rst0_dat", bus0.rdat, 128'd0);
        checkOutput("rst3_ack", 128'(bus3.ack), 128'd0);
        checkOutput("rst3_dat", bus3.rdat, 128'd0);
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // Full write then read back, zero wait states
        applyStimulus(0, 1'b1, 32'h20, 16'hFFFF, D1, lat, ak, er, rd, akNext);
        checkOutput("t1_wr_lat",   128'(lat), 128'd1);
        checkOutput("t1_wr_ack",   128'(ak), 128'd1);
        checkOutput("t1_wr_err",   128'(er), 128'd0);
        checkOutput("t1_wr_pulse", 128'(akNext), 128'd0);
        applyStimulus(0, 1'b0, 32'h20, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t1_rd_lat",   128'(lat), 128'd1);
        checkOutput("t1_rd_ack",   128'(ak), 128'd1);
        checkOutput("t1_rd_dat",   rd, D1);

        // Partial byte-lane write
        applyStimulus(0, 1'b1, 32'h20, 16'h000F, {128{1'b1}}, lat, ak, er, rd, akNext);
        checkOutput("t2_wr_ack", 128'(ak), 128'd1);
        applyStimulus(0, 1'b0, 32'h20, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t2_rd_dat", rd, D2);

        // Out-of-range read and write; 0x1000 would alias line 0 if bits were dropped
        applyStimulus(0, 1'b1, 32'h0, 16'hFFFF, D3, lat, ak, er, rd, akNext);
        checkOutput("t4_init_ack", 128'(ak), 128'd1);
        applyStimulus(0, 1'b0, 32'h1000, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t4_rd_lat",   128'(lat), 128'd1);
        checkOutput("t4_rd_err",   128'(er), 128'd1);
        checkOutput("t4_rd_ack",   128'(ak), 128'd0);
        checkOutput("t4_rd_pulse", 128'(akNext), 128'd0);
        checkOutput("t4_rd_hold",  rd, D2);
        applyStimulus(0, 1'b1, 32'h1000, 16'hFFFF, D1, lat, ak, er, rd, akNext);
        checkOutput("t4_wr_err",   128'(er), 128'd1);
        checkOutput("t4_wr_ack",   128'(ak), 128'd0);
        applyStimulus(0, 1'b0, 32'h0, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t4_line0",    rd, D3);

        // Load port, alone and colliding with a bus write on the same edge
        applyStimulus(0, 1'b1, 32'h10, 16'hFFFF, '0, lat, ak, er, rd, akNext);
        @(negedge clk);
        ldWe = 1'b1; ldIdx = 10'd5; ldWord = 32'hF0081003;
        @(negedge clk);
        ldWe = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t5_load", rd, 128'h00000000_00000000_F0081003_00000000);
        @(negedge clk);
        driveBus(0, 1'b1, 1'b1, 1'b1, 32'h10, 16'h0030, {16{8'hAA}});
        ldWe = 1'b1; ldIdx = 10'd5; ldWord = 32'h12345678;
        @(posedge clk);
        #1;
        ldWe = 1'b0;
        checkOutput("t5_sim_ack", 128'(bus0.ack), 128'd1);
        driveBus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(0, 1'b0, 32'h10, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t5_collide", rd, 128'h00000000_00000000_1234AAAA_00000000);

        // Three wait states: latency, abort and reset in WAIT
        applyStimulus(3, 1'b1, 32'h30, 16'hFFFF, D1, lat, ak, er, rd, akNext);
        checkOutput("t3_wr_lat",   128'(lat), 128'd4);
        checkOutput("t3_wr_pulse", 128'(akNext), 128'd0);
        applyStimulus(3, 1'b0, 32'h30, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t3_rd_lat",   128'(lat), 128'd4);
        checkOutput("t3_rd_dat",   rd, D1);

        @(negedge clk);
        driveBus(3, 1'b1, 1'b1, 1'b1, 32'h30, 16'hFFFF, D4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        driveBus(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | bus3.ack | bus3.err;
        end
        checkOutput("t3_abort_resp", 128'(seen), 128'd0);
        applyStimulus(3, 1'b0, 32'h30, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t3_abort_lat", 128'(lat), 128'd4);
        checkOutput("t3_abort_mem", rd, D1);

        @(negedge clk);
        driveBus(3, 1'b1, 1'b1, 1'b1, 32'h30, 16'hFFFF, D4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        #1;
        checkOutput("t6_ack", 128'(bus3.ack), 128'd0);
        checkOutput("t6_err", 128'(bus3.err), 128'd0);
        checkOutput("t6_dat", bus3.rdat, 128'd0);
        driveBus(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst3 = 1'b0;
        applyStimulus(3, 1'b0, 32'h30, 16'h0000, '0, lat, ak, er, rd, akNext);
        checkOutput("t6_rd_lat", 128'(lat), 128'd4);
        checkOutput("t6_rd_dat", rd, D1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
